// File: rtl/rca_seq_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder controller.
// Holds the controller state encoding and the slice width.
package rca_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB = 4;

    function automatic int nib_count(input int width);
        return width / NIB;
    endfunction

    // Never below 1 so the index register always has at least one bit.
    function automatic int nib_idx_w(input int width);
        int w;
        w = $clog2(nib_count(width));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rca_seq_add32_rca4.sv
// Combinational 4-bit ripple-carry adder slice.
// The controller reuses this one slice for every nibble of the operands.
module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

// File: rtl/rca_seq_add32.sv
// Multi-cycle add/subtract controller: walks one rca4 slice across the
// operands LSB nibble first, then holds the result until it is taken.
module rca_seq_add32
    import rca_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             unsign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high. in_ready is high only in IDLE, out_valid only in DONE;
    // neither depends combinationally on the opposite side's signal.

    localparam int NNIB = nib_count(WIDTH);
    localparam int KW   = nib_idx_w(WIDTH);
    localparam int MSB  = WIDTH - 1;
    localparam logic [KW-1:0] K_LAST = KW'(NNIB - 1);

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic             carry_r;
    logic             sub_r;
    logic             unsign_r;
    logic             cout_r;
    logic             ovf_r;
    logic [KW-1:0]    k;

    logic [NIB-1:0]   a_nib;
    logic [NIB-1:0]   b_nib;
    logic [NIB-1:0]   sum_nib;
    logic             slice_cout;
    logic             accept;
    logic             last_step;
    logic             ovf_calc;

    // Nibble select from the registered operands feeds the single slice.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NNIB; i++) begin
            if (k == KW'(i)) begin
                a_nib = a_r[i*NIB +: NIB];
                b_nib = b_r[i*NIB +: NIB];
            end
        end
    end

    rca4 u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_r),
        .s    (sum_nib),
        .cout (slice_cout)
    );

    assign accept    = (state == IDLE) && in_valid;
    assign last_step = (state == RUN) && (k == K_LAST);

    // Evaluated during the last RUN cycle, when the slice is producing the
    // MSB nibble and the final carry.
    always_comb begin
        ovf_calc = 1'b0;
        if (unsign_r) begin
            ovf_calc = sub_r ? ~slice_cout : slice_cout;
        end else begin
            ovf_calc = (a_r[MSB] == b_r[MSB]) && (sum_nib[NIB-1] != a_r[MSB]);
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (k == K_LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            carry_r  <= 1'b0;
            sub_r    <= 1'b0;
            unsign_r <= 1'b0;
            k        <= '0;
        end else if (accept) begin
            a_r      <= a;
            b_r      <= sub ? ~b : b;
            carry_r  <= sub;
            sub_r    <= sub;
            unsign_r <= unsign;
            k        <= '0;
        end else if (state == RUN) begin
            carry_r <= slice_cout;
            if (k != K_LAST) begin
                k <= k + 1'b1;
            end
        end
    end

    // Result nibbles only change during RUN, so s is quiet while out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < NNIB; i++) begin
                if (k == KW'(i)) begin
                    s_r[i*NIB +: NIB] <= sum_nib;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (last_step) begin
            cout_r <= slice_cout;
            ovf_r  <= ovf_calc;
        end
    end

    assign s         = s_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign dbg_state = state;

endmodule
